// File: rtl/irq_controller.sv
// Memory-mapped priority interrupt controller: per-channel mask, edge/level mode,
// nested in-service tracking, EOI, and vector return during intack.
module irq_controller #(
  parameter int          NUM_IRQ   = 8,
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 16,
  parameter int unsigned BASE_ADDR = 'h0f0,
  parameter int unsigned VEC_BASE  = 'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               memwt,
  output logic [DATA_W-1:0]  rdata,
  output logic               sel,
  output logic               INT,
  input  logic               intack,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int IW = 5;

  localparam logic [2:0] OFF_MASK = 3'd0;
  localparam logic [2:0] OFF_MODE = 3'd1;
  localparam logic [2:0] OFF_PEND = 3'd2;
  localparam logic [2:0] OFF_ISR  = 3'd3;
  localparam logic [2:0] OFF_EOI  = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;

  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_pend_e;
  logic [NUM_IRQ-1:0] r_inservice;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic               r_intack_q;
  logic               r_int;

  logic [ADDR_W-1:0]  w_off;
  logic               w_wr;
  logic               w_wr_mask;
  logic               w_wr_mode;
  logic               w_wr_eoi;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_isr_low;
  logic [NUM_IRQ-1:0] w_below;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_win_oh;
  logic [NUM_IRQ-1:0] w_ack_oh;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend_next;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [IW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic               w_ack_fire;
  logic [DATA_W-1:0]  w_reg_rd;
  logic               w_unused;

  // Offset wraps to a large value below BASE_ADDR, so one compare covers both bounds.
  assign w_off     = address - ADDR_W'(BASE_ADDR);
  assign sel       = (w_off < ADDR_W'(6));
  assign w_wr      = memwt & sel;
  assign w_wr_mask = w_wr && (w_off[2:0] == OFF_MASK);
  assign w_wr_mode = w_wr && (w_off[2:0] == OFF_MODE);
  assign w_wr_eoi  = w_wr && (w_off[2:0] == OFF_EOI);
  assign w_w1c     = (w_wr && (w_off[2:0] == OFF_PEND)) ? wdata[NUM_IRQ-1:0] : '0;
  assign w_unused  = ^wdata;

  assign w_pending = (r_mode & r_pend_e) | (~r_mode & irq);

  // Lowest set in-service bit minus one gives the preemption window; all ones when idle.
  assign w_isr_low = r_inservice & (~r_inservice + 1'b1);
  assign w_below   = w_isr_low - 1'b1;
  assign w_elig    = w_pending & r_mask & w_below;
  assign w_win_oh  = w_elig & (~w_elig + 1'b1);
  assign w_win_valid = |w_elig;

  always_comb begin
    w_win_idx = IW'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_idx = IW'(i);
    end
  end

  assign w_ack_fire = intack & ~r_intack_q & w_win_valid;
  assign w_ack_oh   = w_ack_fire ? w_win_oh : '0;
  assign w_rise     = irq & ~r_irq_q;

  // Edge set is ORed in last so it wins over W1C and acknowledge clears.
  assign w_pend_next = ((r_pend_e & ~w_w1c & ~w_ack_oh) | w_rise) & r_mode;
  assign w_isr_next  = (w_wr_eoi ? (r_inservice & ~w_isr_low) : r_inservice) | w_ack_oh;

  always_comb begin
    w_reg_rd = '0;
    if (sel) begin
      case (w_off[2:0])
        OFF_MASK: w_reg_rd[NUM_IRQ-1:0] = r_mask;
        OFF_MODE: w_reg_rd[NUM_IRQ-1:0] = r_mode;
        OFF_PEND: w_reg_rd[NUM_IRQ-1:0] = w_pending;
        OFF_ISR:  w_reg_rd[NUM_IRQ-1:0] = r_inservice;
        OFF_STAT: begin
          w_reg_rd[15]     = r_int;
          w_reg_rd[IW-1:0] = w_win_idx;
        end
        default:  w_reg_rd = '0;
      endcase
    end
    rdata = intack ? (DATA_W'(VEC_BASE) + DATA_W'(w_win_idx)) : w_reg_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= '0;
      r_mode      <= '0;
      r_pend_e    <= '0;
      r_inservice <= '0;
      r_irq_q     <= '0;
      r_irq_ack   <= '0;
      r_intack_q  <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= wdata[NUM_IRQ-1:0];
      if (w_wr_mode) r_mode <= wdata[NUM_IRQ-1:0];
      r_pend_e    <= w_pend_next;
      r_inservice <= w_isr_next;
      r_irq_q     <= irq;
      r_irq_ack   <= w_ack_oh;
      r_intack_q  <= intack;
      r_int       <= w_win_valid;
    end
  end

  assign INT     = r_int;
  assign irq_ack = r_irq_ack;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic, all
// compared against a behavioural model of the interrupt controller.
module tb_irq_controller;

  localparam int N    = 8;
  localparam int BASE = 'h0f0;
  localparam int VEC  = 'h0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq = '0;
  logic [11:0]  address = '0;
  logic [15:0]  wdata = '0;
  logic         memwt = 1'b0;
  logic [15:0]  rdata;
  logic         sel;
  logic         int_out;
  logic         intack = 1'b0;
  logic [N-1:0] irq_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit [N-1:0] m_mask, m_mode, m_pend_e, m_isr, m_irq_q, m_ack;
  bit         m_intack_q, m_int;

  logic [15:0] obs_rdata;
  int          ack_pulses;

  irq_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq     (irq),
    .address (address),
    .wdata   (wdata),
    .memwt   (memwt),
    .rdata   (rdata),
    .sel     (sel),
    .INT     (int_out),
    .intack  (intack),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend_bit(int i);
    return m_mode[i] ? m_pend_e[i] : irq[i];
  endfunction

  function automatic bit [N-1:0] m_pending();
    bit [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_pend_bit(i);
    return p;
  endfunction

  // Highest priority pending+enabled channel above the most urgent one in service.
  function automatic int m_winner();
    int lowest_isr;
    lowest_isr = N;
    for (int i = N - 1; i >= 0; i--) if (m_isr[i]) lowest_isr = i;
    for (int i = 0; i < lowest_isr; i++) if (m_pend_bit(i) && m_mask[i]) return i;
    return N;
  endfunction

  function automatic int m_read(int off, bit ack);
    if (ack) return (VEC + m_winner()) & 'hffff;
    case (off)
      0: return int'(m_mask);
      1: return int'(m_mode);
      2: return int'(m_pending());
      3: return int'(m_isr);
      5: return (int'(m_int) << 15) | m_winner();
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mask = '0; m_mode = '0; m_pend_e = '0; m_isr = '0;
    m_irq_q = '0; m_ack = '0; m_intack_q = 1'b0; m_int = 1'b0;
  endtask

  // One bus cycle. off = register offset from BASE; values outside 0..5 miss the block.
  task automatic cycle(input bit [N-1:0] irq_v, input int off, input bit wr,
                       input bit [15:0] wd, input bit ack);
    int         win;
    bit         hit, fire;
    bit [N-1:0] n_mask, n_mode, n_pend, n_isr, n_ack;
    @(negedge clk);
    irq     = irq_v;
    address = 12'(BASE + off);
    wdata   = wd;
    memwt   = wr;
    intack  = ack;
    #1;
    hit = (off >= 0 && off <= 5);
    win = m_winner();
    obs_rdata = rdata;
    check_val("sel", sel, hit);
    check_val("rdata", rdata, hit || ack ? m_read(off, ack) : (ack ? m_read(off, ack) : 0));

    fire   = ack && !m_intack_q && (win < N);
    n_mask = (wr && hit && off == 0) ? wd[N-1:0] : m_mask;
    n_mode = (wr && hit && off == 1) ? wd[N-1:0] : m_mode;
    n_isr  = m_isr;
    if (wr && hit && off == 4) begin
      for (int i = 0; i < N; i++) begin
        if (n_isr[i]) begin
          n_isr[i] = 1'b0;
          break;
        end
      end
    end
    if (fire) n_isr[win] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i]) n_pend[i] = 1'b0;
      else begin
        n_pend[i] = m_pend_e[i];
        if (wr && hit && off == 2 && wd[i]) n_pend[i] = 1'b0;
        if (fire && win == i) n_pend[i] = 1'b0;
        if (irq_v[i] && !m_irq_q[i]) n_pend[i] = 1'b1;
      end
    end
    n_ack = '0;
    if (fire) n_ack[win] = 1'b1;

    @(posedge clk);
    m_int      = (win < N);
    m_mask     = n_mask;
    m_mode     = n_mode;
    m_isr      = n_isr;
    m_pend_e   = n_pend;
    m_ack      = n_ack;
    m_irq_q    = irq_v;
    m_intack_q = ack;
    #1;
    check_val("INT", int_out, m_int);
    check_val("irq_ack", irq_ack, m_ack);
    if (irq_ack != '0) ack_pulses++;
  endtask

  task automatic wr_reg(input int off, input bit [15:0] d, input bit [N-1:0] irq_v = '0);
    cycle(irq_v, off, 1'b1, d, 1'b0);
  endtask

  task automatic rd_reg(input int off, input bit [N-1:0] irq_v = '0);
    cycle(irq_v, off, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_ack(input int off = 6, input bit [N-1:0] irq_v = '0);
    cycle(irq_v, off, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    irq     = '0;
    memwt   = 1'b0;
    intack  = 1'b0;
    address = 12'(BASE + 3);
    model_reset();
    #1;
    check_val("rst_INT", int_out, 1'b0);
    check_val("rst_irq_ack", irq_ack, '0);
    check_val("rst_isr", rdata, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit [N-1:0] irq_r;
    bit [N-1:0] flip;
    int         off;
    bit         wr, ack;

    model_reset();
    ack_pulses = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    for (int o = 0; o < 5; o++) begin
      rd_reg(o);
      check_val("reset_reg", obs_rdata, 16'h0);
    end
    rd_reg(5);
    check_val("reset_status", obs_rdata, 16'h0008);

    // edge capture on channel 3
    wr_reg(1, 16'h00ff);
    wr_reg(0, 16'h0008);
    cycle(8'h08, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(2);
    check_val("edge_pend", obs_rdata, 16'h0008);
    check_val("edge_int", int_out, 1'b1);
    do_ack(2);
    check_val("edge_vec", obs_rdata, 16'h0003);
    check_val("edge_ack", irq_ack, 8'h08);
    rd_reg(2);
    check_val("edge_pend_clr", obs_rdata, 16'h0000);
    check_val("edge_ack_one", irq_ack, 8'h00);
    check_val("edge_int_low", int_out, 1'b0);
    rd_reg(3);
    check_val("edge_isr", obs_rdata, 16'h0008);
    wr_reg(4, 16'h0);

    // priority and nesting
    wr_reg(0, 16'h00ff);
    cycle(8'h20, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    do_ack();
    check_val("nest_vec5", obs_rdata, 16'h0005);
    rd_reg(3);
    check_val("nest_isr20", obs_rdata, 16'h0020);
    cycle(8'h40, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    rd_reg(6);
    check_val("nest_low_blocked", int_out, 1'b0);
    cycle(8'h02, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    check_val("nest_preempt_int", int_out, 1'b1);
    do_ack();
    check_val("nest_vec1", obs_rdata, 16'h0001);
    rd_reg(3);
    check_val("nest_isr22", obs_rdata, 16'h0022);
    wr_reg(4, 16'h0);
    rd_reg(3);
    check_val("nest_eoi1", obs_rdata, 16'h0020);
    wr_reg(4, 16'h0);
    rd_reg(6);
    rd_reg(5);
    check_val("nest_status6", obs_rdata, 16'h8006);
    do_ack();
    rd_reg(6);
    wr_reg(4, 16'h0);

    // level mode on channel 0
    wr_reg(1, 16'h0000);
    wr_reg(0, 16'h0001);
    rd_reg(6, 8'h01);
    rd_reg(6, 8'h01);
    check_val("lvl_int", int_out, 1'b1);
    do_ack(6, 8'h01);
    check_val("lvl_vec0", obs_rdata, 16'h0000);
    check_val("lvl_ack", irq_ack, 8'h01);
    rd_reg(6, 8'h01);
    check_val("lvl_int_isr", int_out, 1'b0);
    wr_reg(4, 16'h0, 8'h01);
    rd_reg(6, 8'h01);
    check_val("lvl_reraise", int_out, 1'b1);
    wr_reg(2, 16'h0001, 8'h01);
    rd_reg(2, 8'h01);
    check_val("lvl_w1c_ignored", obs_rdata, 16'h0001);
    rd_reg(2, 8'h00);
    check_val("lvl_pend_drop", obs_rdata, 16'h0000);
    check_val("lvl_int_drop", int_out, 1'b0);

    // spurious and long intack
    wr_reg(0, 16'h0000);
    ack_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      do_ack(3);
      check_val("spur_vec", obs_rdata, 16'h0008);
    end
    rd_reg(3);
    check_val("spur_isr", obs_rdata, 16'h0000);
    check_val("spur_no_ack", ack_pulses, 0);
    wr_reg(1, 16'h00ff);
    wr_reg(0, 16'h00ff);
    cycle(8'h10, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    ack_pulses = 0;
    for (int k = 0; k < 3; k++) do_ack();
    rd_reg(6);
    check_val("long_ack_once", ack_pulses, 1);
    wr_reg(4, 16'h0);

    // simultaneous events
    wr_reg(0, 16'h0000);
    cycle(8'h04, 2, 1'b1, 16'h0004, 1'b0);
    rd_reg(2);
    check_val("sim_set_beats_w1c", obs_rdata, 16'h0004);
    wr_reg(2, 16'h0004);
    rd_reg(2);
    check_val("sim_w1c", obs_rdata, 16'h0000);
    wr_reg(0, 16'h00ff);
    cycle(8'h10, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    do_ack();
    rd_reg(6);
    cycle(8'h01, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    cycle(8'h00, 4, 1'b1, 16'h0, 1'b1);
    rd_reg(3);
    check_val("sim_eoi_ack", obs_rdata, 16'h0001);
    wr_reg(4, 16'h0);

    // random traffic
    irq_r = '0;
    for (int n = 0; n < 1500; n++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
      irq_r ^= flip;
      off = $urandom_range(0, 7) - 1;
      wr  = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) begin
        off = 4;
        wr  = 1'b1;
      end
      cycle(irq_r, off, wr, 16'($urandom), ack);
    end

    // reset in the middle of activity
    do_reset();
    wr_reg(1, 16'h00ff);
    wr_reg(0, 16'h00ff);
    cycle(8'h04, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(6);
    do_ack();
    rd_reg(6);
    cycle(8'h01, 6, 1'b0, 16'h0, 1'b0);
    rd_reg(3);
    check_val("pre_rst_isr", obs_rdata, 16'h0004);
    check_val("pre_rst_int", int_out, 1'b1);
    do_reset();
    for (int o = 0; o < 5; o++) begin
      rd_reg(o);
      check_val("post_rst_reg", obs_rdata, 16'h0);
    end
    rd_reg(5);
    check_val("post_rst_status", obs_rdata, 16'h0008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised, memory-mapped priority interrupt controller; replaces the fixed 8-input irq priority mux in the top-level bus decoder.
- Per-channel mask, edge/level mode, pending latches, in-service tracking with nesting, and end-of-interrupt (EOI).
- Sits on the CPU address/data bus beside RAM and peripherals; drives CPU INT and returns the vector during intack.

Parameters:
- NUM_IRQ, 8, number of interrupt channels; legal range 1..16 and must be ≤ DATA_W; channel 0 has highest priority.
- ADDR_W, 12, CPU address width.
- DATA_W, 16, CPU data width.
- BASE_ADDR, 12'h0f0, address of register offset 0.
- VEC_BASE, 16'h0000, vector returned for channel 0; channel i returns VEC_BASE+i.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  device requests, synchronous to clk.
- address  in  ADDR_W  CPU address.
- wdata  in  DATA_W  CPU write data (CPU data_out).
- memwt  in  1  CPU write strobe.
- rdata  out  DATA_W  read data / vector toward CPU data_in mux.
- sel  out  1  combinational; 1 when address is in BASE_ADDR..BASE_ADDR+5.
- INT  out  1  interrupt request to CPU, registered.
- intack  in  1  CPU interrupt acknowledge.
- irq_ack  out  NUM_IRQ  one-cycle acknowledge pulse to the serviced source.

Behaviour:
- Reset (async, rst_n=0): MASK=0, MODE=0, PENDING=0, INSERVICE=0, irq_q=0, intack_q=0, INT=0, irq_ack=0. Any in-flight acknowledge is discarded.
- Register map (offset from BASE_ADDR):
  - 0 MASK: rw; 1 = channel enabled.
  - 1 MODE: rw; 1 = edge, 0 = level.
  - 2 PENDING: r; write-1-to-clear on edge channels only.
  - 3 INSERVICE: r.
  - 4 EOI: w; data ignored; reads 0.
  - 5 STATUS: r; bit15 = INT, bits4:0 = index of current winner, or NUM_IRQ if none.
- Bits at and above NUM_IRQ read 0 and ignore writes. Unmapped offsets read 0. rdata is combinational. Writes take effect at the clk edge where memwt=1 and sel=1.
- Edge channels:
  - irq_q is irq registered once.
  - Rising edge detect = irq & ~irq_q; it sets PENDING[i].
  - Set beats a same-cycle W1C clear and a same-cycle intack clear.
- Level channels: PENDING[i] tracks irq[i] directly each cycle and is not latched; W1C has no effect.
- Priority:
  - eligible = PENDING & MASK, restricted to indices strictly lower than the lowest set INSERVICE bit. This is nesting: only a higher priority request preempts.
  - The winner is the lowest-index eligible channel.
- INT: register loaded each cycle with |eligible, giving 1 cycle latency from eligibility to INT.
- Acknowledge handshake:
  - While intack=1, rdata = VEC_BASE + winner index, overriding the register read. With no winner it is the spurious vector VEC_BASE+NUM_IRQ.
  - Action happens only on the first cycle of an intack pulse (intack & ~intack_q). At that edge: INSERVICE[w] set, edge PENDING[w] cleared, irq_ack[w]=1 for exactly one cycle.
  - Spurious acknowledge: no state change and no irq_ack.
  - Holding intack high for more cycles repeats no action.
- EOI: clears the lowest-index set INSERVICE bit. With INSERVICE=0 it has no effect.
  - EOI and intack action in the same cycle: EOI is applied to the old INSERVICE, then the new bit is set. If both target the same bit, it ends up set.
- Level sources must be deasserted by the device after irq_ack or via the ISR. Otherwise the request re-raises INT after EOI.
- A changed MASK or MODE affects eligibility on the next cycle. Masking a channel does not clear PENDING.

Test Plan:
- Reset mid-operation: INSERVICE=0x04 and INT=1, assert rst_n=0 asynchronously -> INT=0, INSERVICE=0, irq_ack=0 immediately; all registers read 0 after release.
- Edge capture: MODE=0xFF, MASK=0x08, 1-cycle pulse on irq[3] -> PENDING=0x08, INT=1 one cycle later; intack -> rdata=0x0003, irq_ack=0x08 for one cycle, PENDING=0, INSERVICE=0x08, INT=0.
- Priority and nesting: MASK=0xFF, edge. Pulse irq[5], ack -> INSERVICE=0x20. Pulse irq[6] -> INT stays 0. Pulse irq[1] -> INT=1, vector 0x0001, INSERVICE=0x22. EOI -> 0x20. EOI -> 0x00, then INT=1 for channel 6.
- Level mode: MODE=0, MASK=0x01, hold irq[0]=1, ack then EOI -> INT reasserts. Drop irq[0] -> PENDING[0]=0 and INT=0 next cycle. W1C to PENDING has no effect.
- Spurious acknowledge and long intack: MASK=0, intack held 3 cycles -> rdata=0x0008, no irq_ack, no state change. With a valid winner, intack held 3 cycles -> exactly one irq_ack pulse.
- Simultaneous events: edge on irq[2] in the same cycle as a W1C of bit 2 -> PENDING[2]=1. EOI and intack in the same cycle with INSERVICE=0x10 and winner 0 -> INSERVICE=0x01.
